// File: rtl/spi_slave_pkg.sv
// rtl/spi_slave_pkg.sv - shared types and defaults for the SPI slave front end
package spi_slave_pkg;

  localparam int DEF_RX_WIDTH = 10;
  localparam int DEF_TX_WIDTH = 8;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    CHK_CMD   = 3'd1,
    WRITE     = 3'd2,
    READ_ADD  = 3'd3,
    READ_DATA = 3'd4
  } state_t;

  // Command field carried in rx_data[9:8]; decoded by the RAM side.
  typedef enum logic [1:0] {
    WR_ADDR = 2'b00,
    WR_DATA = 2'b01,
    RD_ADDR = 2'b10,
    RD_DATA = 2'b11
  } cmd_t;

endpackage

// File: rtl/spi_tx_shifter.sv
// rtl/spi_tx_shifter.sv - parallel-load PISO driving MISO, MSB first
module spi_tx_shifter #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             load,
  input  logic [WIDTH-1:0] data,
  output logic             miso,
  output logic             busy,
  output logic             done
);

  localparam int CW = $clog2(WIDTH);

  logic [WIDTH-1:0] sh;
  logic [CW-1:0]    cnt;

  // The MSB goes out on the load edge, so the register keeps only the remaining bits.
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      sh   <= '0;
      cnt  <= '0;
      miso <= 1'b0;
      busy <= 1'b0;
      done <= 1'b0;
    end else if (load) begin
      sh   <= {data[WIDTH-2:0], 1'b0};
      cnt  <= CW'(WIDTH - 1);
      miso <= data[WIDTH-1];
      busy <= 1'b1;
      done <= 1'b0;
    end else if (busy) begin
      if (cnt != '0) begin
        miso <= sh[WIDTH-1];
        sh   <= {sh[WIDTH-2:0], 1'b0};
        cnt  <= cnt - 1'b1;
      end else begin
        miso <= 1'b0;
        busy <= 1'b0;
        done <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/spi_slave_fsm.sv
// rtl/spi_slave_fsm.sv - SPI slave frame FSM: MOSI deserialiser to RAM, RAM read data out on MISO
module spi_slave_fsm
  import spi_slave_pkg::*;
#(
  parameter int RX_WIDTH = DEF_RX_WIDTH,
  parameter int TX_WIDTH = DEF_TX_WIDTH
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                SS_n,
  input  logic                MOSI,
  output logic                MISO,
  output logic [RX_WIDTH-1:0] rx_data,
  output logic                rx_valid,
  input  logic [TX_WIDTH-1:0] tx_data,
  input  logic                tx_valid
);

  localparam logic [3:0] WORD_BITS = 4'(RX_WIDTH);
  localparam logic [3:0] LAST_BIT  = 4'(RX_WIDTH - 1);

  state_t     state;
  logic [3:0] bit_cnt;
  logic       rd_addr_seen;

  logic       tx_load;
  logic       tx_clear;
  logic       tx_busy;
  logic       tx_done;

  // Read data is accepted once per READ_DATA frame, only after the full word is in.
  assign tx_load  = (state == READ_DATA) && !SS_n && (bit_cnt == WORD_BITS) &&
                    tx_valid && !tx_busy && !tx_done;
  assign tx_clear = SS_n && (state != IDLE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      rx_data      <= '0;
      rx_valid     <= 1'b0;
      bit_cnt      <= '0;
      rd_addr_seen <= 1'b0;
    end else begin
      rx_valid <= 1'b0;
      if (SS_n) begin
        state   <= IDLE;
        bit_cnt <= '0;
      end else begin
        case (state)
          IDLE: begin
            state   <= CHK_CMD;
            bit_cnt <= '0;
          end
          CHK_CMD: begin
            if (!MOSI)
              state <= WRITE;
            else if (rd_addr_seen)
              state <= READ_DATA;
            else
              state <= READ_ADD;
          end
          WRITE, READ_ADD, READ_DATA: begin
            // Counter parks at WORD_BITS so extra clocks in the frame never start a new word.
            if (bit_cnt != WORD_BITS) begin
              rx_data <= {rx_data[RX_WIDTH-2:0], MOSI};
              bit_cnt <= bit_cnt + 1'b1;
              if (bit_cnt == LAST_BIT) begin
                rx_valid <= 1'b1;
                if (state == READ_ADD)
                  rd_addr_seen <= 1'b1;
                else if (state == READ_DATA)
                  rd_addr_seen <= 1'b0;
              end
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

  spi_tx_shifter #(
    .WIDTH (TX_WIDTH)
  ) u_tx (
    .clk   (clk),
    .rst   (rst),
    .clear (tx_clear),
    .load  (tx_load),
    .data  (tx_data),
    .miso  (MISO),
    .busy  (tx_busy),
    .done  (tx_done)
  );

endmodule
